i2c_temp_poll_sequencer: RTL
============================

Name: i2c_temp_poll_sequencer

Overview:
- Periodically sequences one temperature read from an I2C temperature sensor.
- Each poll drives the pointer-write engine (GO/END_OK/ACK_OK handshake), then a read-word engine with the same handshake.
- Owns the SDA/SCL mux select between the two engines, latches the 16-bit reading and drives the fan-enable decision.
- Sits between the autofan top level and the two I2C engines.

Parameters:
- POLL_DIV, 24'd5000000: PT_CK cycles between poll starts.
- SLAVE_ADDRESS, 8'h98: sensor 8-bit bus address.
- TEMP_PTR, 8'h00: sensor temperature register pointer.
- GO_HOLD, 4'd4: cycles GO is held high before release.
- TIMEOUT, 16'd60000: max cycles waiting for END_OK.
- T_ON, 8'd60: fan-on threshold, upper byte of reading, degrees C.

Ports:
- PT_CK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- ENABLE  in  1  polling enable
- WP_GO  out  1  GO to pointer-write engine
- WP_POINTER  out  8  pointer value, constant TEMP_PTR
- WP_SLAVE_ADDRESS  out  8  constant SLAVE_ADDRESS
- WP_END_OK  in  1  pointer-write engine idle/finished
- WP_ACK_OK  in  1  pointer-write engine ACK result
- RD_GO  out  1  GO to read-word engine
- RD_END_OK  in  1  read engine idle/finished
- RD_ACK_OK  in  1  read engine ACK result
- RD_DATA  in  16  read engine result word
- BUS_SEL  out  1  0 = pointer engine owns SDA/SCL, 1 = read engine
- TEMP  out  16  last good reading
- TEMP_VALID  out  1  at least one good reading since reset
- FAN_ON  out  1  fan enable
- ERR  out  1  sticky error, cleared by next good poll
- NACK_CNT  out  8  saturating count of failed polls

Behaviour:
- Reset values: WP_GO=0, RD_GO=0, BUS_SEL=0, TEMP=0, TEMP_VALID=0, FAN_ON=1 (fail-safe), ERR=0, NACK_CNT=0, state IDLE, tick counter=0.
- Tick counter counts 0..POLL_DIV-1 while ENABLE=1 and wraps. tick=1 for one cycle at wrap. Counter is held at 0 while ENABLE=0.
- An engine handshake has three phases: GO=1 for GO_HOLD cycles; GO=0; wait END_OK=0 (started), then END_OK=1 (done).
- States:
  - IDLE: on tick go to WP_GO with BUS_SEL=0.
  - WP_GO: WP_GO=1 for GO_HOLD cycles, then WP_REL.
  - WP_REL: WP_GO=0; wait WP_END_OK=0, then WP_BUSY.
  - WP_BUSY: wait WP_END_OK=1. If WP_ACK_OK=1, go to RD_GO and set BUS_SEL=1 in the same cycle. Otherwise go to FAIL.
  - RD_GO: RD_GO=1 for GO_HOLD cycles, then RD_REL.
  - RD_REL: RD_GO=0; wait RD_END_OK=0, then RD_BUSY.
  - RD_BUSY: wait RD_END_OK=1. If RD_ACK_OK=1, go to UPDATE; else FAIL.
  - UPDATE: TEMP<=RD_DATA, TEMP_VALID<=1, ERR<=0, evaluate FAN_ON, BUS_SEL<=0, then IDLE.
  - FAIL: ERR<=1, NACK_CNT<=NACK_CNT+1 saturating at 8'hFF, FAN_ON<=1, BUS_SEL<=0, then IDLE.
- Timeout: one cycle counter runs in WP_REL, WP_BUSY, RD_REL and RD_BUSY, cleared on entry to each. Reaching TIMEOUT forces FAIL.
- Fan decision without the optional feature: FAN_ON = signed TEMP[15:8] >= T_ON. Negative readings give 0.
- Ticks arriving while not in IDLE are dropped, not queued.
- ENABLE=0 mid-poll: the current poll completes; no new poll starts.
- BUS_SEL changes only while both GO outputs are 0 and the previous engine reports END_OK=1.
- Reset mid-poll: all outputs return to reset values immediately; GO outputs drop asynchronously.

Optional Feature:
- Macro: AUTOFAN_HYST_EN.
- Defined: adds parameter T_OFF (default 8'd55, must be < T_ON). FAN_ON sets when TEMP[15:8] >= T_ON, clears when TEMP[15:8] < T_OFF, and holds between the two.
- Undefined: single-threshold compare as above; T_OFF absent.

Test Plan:
- POLL_DIV=100, engine models ACK, RD_DATA=16'h3C80 -> one WP then one RD handshake per tick, GO high exactly 4 cycles; TEMP=16'h3C80, TEMP_VALID=1, FAN_ON=1, ERR=0.
- WP_ACK_OK=0 -> no RD_GO pulse; ERR=1, NACK_CNT=1, BUS_SEL=0, TEMP unchanged. Next good poll -> ERR=0.
- RD_END_OK held 0 -> FAIL after TIMEOUT cycles (set TIMEOUT=200); ERR=1, FAN_ON=1.
- 256 consecutive NACK polls -> NACK_CNT saturates at 8'hFF.
- AUTOFAN_HYST_EN defined: readings 61, 57, 54, 57 (upper byte) -> FAN_ON 1, 1, 0, 0.
- RESET_N low during RD_BUSY -> RD_GO=0, BUS_SEL=0, TEMP=0, FAN_ON=1 at once; after release, first poll waits a full POLL_DIV.

Source files
------------

// File: rtl/i2c_temp_poll_sequencer.sv
// rtl/i2c_temp_poll_sequencer.sv - periodic I2C temperature poll sequencer with fan decision
// Optional feature macro: AUTOFAN_HYST_EN (adds T_OFF and two-threshold fan hysteresis)
`timescale 1ns/100ps
module i2c_temp_poll_sequencer #(
  parameter logic [23:0] POLL_DIV      = 24'd5000000,
  parameter logic [7:0]  SLAVE_ADDRESS = 8'h98,
  parameter logic [7:0]  TEMP_PTR      = 8'h00,
  parameter logic [3:0]  GO_HOLD       = 4'd4,
  parameter logic [15:0] TIMEOUT       = 16'd60000,
  parameter logic [7:0]  T_ON          = 8'd60
`ifdef AUTOFAN_HYST_EN
  ,
  parameter logic [7:0]  T_OFF         = 8'd55
`endif
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  output logic        WP_GO,
  output logic [7:0]  WP_POINTER,
  output logic [7:0]  WP_SLAVE_ADDRESS,
  input  logic        WP_END_OK,
  input  logic        WP_ACK_OK,
  output logic        RD_GO,
  input  logic        RD_END_OK,
  input  logic        RD_ACK_OK,
  input  logic [15:0] RD_DATA,
  output logic        BUS_SEL,
  output logic [15:0] TEMP,
  output logic        TEMP_VALID,
  output logic        FAN_ON,
  output logic        ERR,
  output logic [7:0]  NACK_CNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_WP_GO, S_WP_REL, S_WP_BUSY,
    S_RD_GO, S_RD_REL, S_RD_BUSY, S_UPDATE, S_FAIL
  } state_t;

  state_t             state, next_state;
  logic [23:0]        tick_cnt;
  logic               tick;
  logic [3:0]         hold_cnt;
  logic               hold_done;
  logic [15:0]        to_cnt;
  logic               wait_state;
  logic               to_hit;
  logic signed [7:0]  rd_deg;
  logic               fan_next;

  assign WP_POINTER       = TEMP_PTR;
  assign WP_SLAVE_ADDRESS = SLAVE_ADDRESS;

  assign tick       = ENABLE && (tick_cnt == POLL_DIV - 24'd1);
  assign hold_done  = (hold_cnt == GO_HOLD - 4'd1);
  assign wait_state = (state == S_WP_REL) || (state == S_WP_BUSY) ||
                      (state == S_RD_REL) || (state == S_RD_BUSY);
  assign to_hit     = wait_state && (to_cnt == TIMEOUT - 16'd1);
  assign rd_deg     = RD_DATA[15:8];

  // Poll interval counter; parked at zero while polling is disabled
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N)                          tick_cnt <= '0;
    else if (!ENABLE || tick)              tick_cnt <= '0;
    else                                   tick_cnt <= tick_cnt + 24'd1;
  end

  // GO hold counter runs only while a GO state is active
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N)                                   hold_cnt <= '0;
    else if ((state == S_WP_GO || state == S_RD_GO) && !hold_done)
                                                    hold_cnt <= hold_cnt + 4'd1;
    else                                            hold_cnt <= '0;
  end

  // Engine watchdog, restarted on entry to every wait state
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N)                              to_cnt <= '0;
    else if (!wait_state || next_state != state) to_cnt <= '0;
    else                                       to_cnt <= to_cnt + 16'd1;
  end

  // State register
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic: two GO/release/busy handshakes per poll
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (tick) next_state = S_WP_GO;
      S_WP_GO:   if (hold_done) next_state = S_WP_REL;
      S_WP_REL:  if (!WP_END_OK) next_state = S_WP_BUSY;
                 else if (to_hit) next_state = S_FAIL;
      S_WP_BUSY: if (WP_END_OK) next_state = WP_ACK_OK ? S_RD_GO : S_FAIL;
                 else if (to_hit) next_state = S_FAIL;
      S_RD_GO:   if (hold_done) next_state = S_RD_REL;
      S_RD_REL:  if (!RD_END_OK) next_state = S_RD_BUSY;
                 else if (to_hit) next_state = S_FAIL;
      S_RD_BUSY: if (RD_END_OK) next_state = RD_ACK_OK ? S_UPDATE : S_FAIL;
                 else if (to_hit) next_state = S_FAIL;
      S_UPDATE:  next_state = S_IDLE;
      S_FAIL:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // GO strobes decode straight from state so reset drops them at once
  always_comb begin
    WP_GO = 1'b0;
    RD_GO = 1'b0;
    if (state == S_WP_GO) WP_GO = 1'b1;
    if (state == S_RD_GO) RD_GO = 1'b1;
  end

`ifdef AUTOFAN_HYST_EN
  // Fan decision with hysteresis band between T_OFF and T_ON
  always_comb begin
    fan_next = FAN_ON;
    if (rd_deg >= $signed(T_ON))       fan_next = 1'b1;
    else if (rd_deg < $signed(T_OFF))  fan_next = 1'b0;
  end
`else
  // Single-threshold fan decision on the signed whole-degree byte
  always_comb begin
    fan_next = (rd_deg >= $signed(T_ON));
  end
`endif

  // Result registers: bus select, reading, status and fan enable
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      BUS_SEL    <= 1'b0;
      TEMP       <= '0;
      TEMP_VALID <= 1'b0;
      FAN_ON     <= 1'b1;
      ERR        <= 1'b0;
      NACK_CNT   <= '0;
    end else begin
      if (state == S_WP_BUSY && next_state == S_RD_GO) BUS_SEL <= 1'b1;
      case (state)
        S_UPDATE: begin
          TEMP       <= RD_DATA;
          TEMP_VALID <= 1'b1;
          ERR        <= 1'b0;
          FAN_ON     <= fan_next;
          BUS_SEL    <= 1'b0;
        end
        S_FAIL: begin
          ERR     <= 1'b1;
          FAN_ON  <= 1'b1;
          BUS_SEL <= 1'b0;
          if (NACK_CNT != 8'hFF) NACK_CNT <= NACK_CNT + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
